fifo_wr_arbiter: RTL



---
 rtl/fifo_arb_pkg.sv | 21 ++
 rtl/rr_picker.sv | 30 +++
 rtl/fifo_wr_arbiter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// Holds the arbiter state encoding and the circular index step.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  function automatic int gid_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int rr_next(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

  localparam int NREQ_DEF = 4;
  localparam int GID_W = gid_width(NREQ_DEF);

endpackage

// File: rtl/rr_picker.sv
// Circular first-valid search starting at the round-robin pointer.
// Purely combinational; sel falls back to rr_ptr when nothing is valid.
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int GW   = 2
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [GW-1:0]   rr_ptr,
  output logic            found,
  output logic [GW-1:0]   sel
);

  int idx;

  always_comb begin
    found = 1'b0;
    sel   = rr_ptr;
    idx   = int'(rr_ptr);
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        sel   = GW'(idx);
      end
      idx = rr_next(idx, NREQ);
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter for the async FIFO write port, write-clock domain.
// Bursts lock the port to one owner until last beat or idle timeout.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DATASIZE = 8,
  parameter int NREQ     = 4,
  parameter int TIMEOUT  = 16,
  localparam int GW      = gid_width(NREQ)
) (
  input  logic                     wclk,
  input  logic                     wrst_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*DATASIZE-1:0] req_data,
  input  logic [NREQ-1:0]          req_last,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     wfull,
  output logic                     winc,
  output logic [DATASIZE-1:0]      wdata,
  output logic [GW-1:0]            grant_id,
  output logic                     locked,
  output logic                     abort
);

  localparam logic [7:0] TMO = 8'(TIMEOUT - 1);

  state_t        state, state_n;
  logic [GW-1:0] rr_ptr, rr_n;
  logic [GW-1:0] owner, owner_n;
  logic [GW-1:0] pick, sel, nxt_sel;
  logic [7:0]    idle_cnt, cnt_n;
  logic          found, pick_ok, active;
  logic          last, abort_n;

  rr_picker #(
    .NREQ (NREQ),
    .GW   (GW)
  ) u_pick (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .found     (found),
    .sel       (pick)
  );

  // keep the port quiet while reset is held
  assign pick_ok  = found & wrst_n;
  assign locked   = (state == LOCKED);
  assign sel      = locked ? owner
                  : (pick_ok ? pick : rr_ptr);
  assign active   = locked | pick_ok;
  assign grant_id = sel;
  assign last     = req_last[sel];
  assign nxt_sel  = GW'(rr_next(int'(sel), NREQ));

  always_comb begin
    req_ready = '0;
    if (active && !wfull)
      req_ready[sel] = 1'b1;
  end

  assign winc  = |(req_valid & req_ready);
  assign wdata = req_data[int'(sel)*DATASIZE +: DATASIZE];

  always_comb begin
    state_n = state;
    rr_n    = rr_ptr;
    owner_n = owner;
    cnt_n   = idle_cnt;
    abort_n = 1'b0;
    unique case (state)
      IDLE: begin
        if (winc) begin
          if (last) begin
            rr_n = nxt_sel;
          end else begin
            state_n = LOCKED;
            owner_n = sel;
            cnt_n   = '0;
          end
        end
      end
      LOCKED: begin
        if (winc) begin
          cnt_n = '0;
          if (last) begin
            state_n = IDLE;
            rr_n    = nxt_sel;
          end
        end else if (!req_valid[owner] && !wfull) begin
          // a full FIFO is not owner idleness
          if (idle_cnt == TMO) begin
            state_n = IDLE;
            rr_n    = nxt_sel;
            cnt_n   = '0;
            abort_n = 1'b1;
          end else begin
            cnt_n = idle_cnt + 8'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      owner    <= '0;
      idle_cnt <= '0;
      abort    <= 1'b0;
    end else begin
      state    <= state_n;
      rr_ptr   <= rr_n;
      owner    <= owner_n;
      idle_cnt <= cnt_n;
      abort    <= abort_n;
    end
  end

endmodule
